// File: rtl/mavg_filter_cfg.sv
// Streaming moving-average filter over a runtime-selectable power-of-two window.
// It uses valid/ready on both sides and cfg_load_i restarts warm-up with a new window.
module mavg_filter_cfg #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOG2     = 4,
    parameter int DEFAULT_LOG2 = 3,
    parameter int SIGNED       = 0,
    parameter int ROUND        = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    input  logic                           cfg_load_i,
    input  logic [$clog2(MAX_LOG2+1)-1:0]  win_log2_i,
    output logic [$clog2(MAX_LOG2+1)-1:0]  win_log2_o,
    output logic [MAX_LOG2:0]              fill_o
);
    localparam int DEPTH = 1 << MAX_LOG2;
    localparam int AW    = DATA_WIDTH + MAX_LOG2;
    localparam int LW    = $clog2(MAX_LOG2 + 1);
    localparam int FW    = MAX_LOG2 + 1;

    logic [DATA_WIDTH-1:0] r_buf [DEPTH];
    logic [MAX_LOG2-1:0]   r_wr_ptr;
    logic [AW-1:0]         r_sum;
    logic [FW-1:0]         r_fill;
    logic [LW-1:0]         r_win;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    logic [FW-1:0]         w_win_n;
    logic [FW-1:0]         w_fill_next;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_produce;
    logic [MAX_LOG2-1:0]   w_old_idx;
    logic [DATA_WIDTH-1:0] w_old;
    logic [AW-1:0]         w_x_ext;
    logic [AW-1:0]         w_old_ext;
    logic [AW-1:0]         w_sum_next;
    logic [AW-1:0]         w_rnd;
    logic [AW-1:0]         w_rounded;
    logic signed [AW-1:0]  w_rounded_s;
    logic [DATA_WIDTH-1:0] w_avg;
    logic [LW-1:0]         w_win_cfg;

    assign w_win_n     = FW'(1) << r_win;
    assign w_full      = (r_fill == w_win_n);
    assign w_fill_next = w_full ? r_fill : r_fill + FW'(1);
    assign ready_o     = !cfg_load_i && (!r_valid || ready_i);
    assign w_accept    = valid_i && ready_o;
    assign w_produce   = w_accept && (w_fill_next == w_win_n);

    // Oldest sample in the window; wraps naturally when the window fills the buffer.
    assign w_old_idx = r_wr_ptr - w_win_n[MAX_LOG2-1:0];
    assign w_old     = r_buf[w_old_idx];

    assign w_x_ext   = (SIGNED != 0) ? {{MAX_LOG2{data_i[DATA_WIDTH-1]}}, data_i}
                                     : {{MAX_LOG2{1'b0}}, data_i};
    assign w_old_ext = (SIGNED != 0) ? {{MAX_LOG2{w_old[DATA_WIDTH-1]}}, w_old}
                                     : {{MAX_LOG2{1'b0}}, w_old};

    assign w_sum_next  = r_sum + w_x_ext - (w_full ? w_old_ext : '0);
    assign w_rnd       = (ROUND != 0 && r_win != '0) ? (AW'(1) << (r_win - LW'(1))) : '0;
    assign w_rounded   = w_sum_next + w_rnd;
    assign w_rounded_s = w_rounded;

    always_comb begin
        if (SIGNED != 0) w_avg = DATA_WIDTH'(w_rounded_s >>> r_win);
        else             w_avg = DATA_WIDTH'(w_rounded >> r_win);
    end

    assign w_win_cfg = (win_log2_i > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : win_log2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
            r_win    <= LW'(DEFAULT_LOG2);
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else if (cfg_load_i) begin
            r_win    <= w_win_cfg;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + MAX_LOG2'(1);
                r_sum           <= w_sum_next;
                r_fill          <= w_fill_next;
            end
            // A fresh average replaces a consumed one, keeping full throughput.
            if (w_produce) begin
                r_data  <= w_avg;
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign win_log2_o = r_win;
    assign fill_o     = r_fill;
endmodule
